inv_sub_bytes_seq: RTL and testbench

- AES decryption InvSubBytes stage, the inverse of the forward SubBytes transform.
- Applies the inverse S-box to all 16 bytes of a 128-bit state.
- Time-multiplexes LANES inverse S-boxes, one 32-bit word per cycle.
- Sits between InvShiftRows and AddRoundKey in the iterative decryption datapath, with valid/ready handshakes on both sides.

---
 rtl/inv_sub_bytes_seq_pkg.sv | 35 +++
 rtl/inv_sub_bytes_seq_sbox.sv | 11 +
 rtl/inv_sub_bytes_seq.sv | 81 ++++++++
 tb/tb_inv_sub_bytes_seq.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/inv_sub_bytes_seq_pkg.sv
// Shared AES decryption constants: state geometry, InvSubBytes FSM encoding,
// and the inverse S-box table.
package inv_sub_bytes_seq_pkg;

   localparam int BYTE   = 8;
   localparam int DWORD  = 32;
   localparam int LENGTH = 128;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Inverse S-box, indexed by the substituted byte value.
   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

endpackage

// File: rtl/inv_sub_bytes_seq_sbox.sv
// Single-byte inverse S-box: pure combinational table lookup.
module inv_sbox
   import inv_sub_bytes_seq_pkg::*;
(
   input  logic [BYTE-1:0] data,
   output logic [BYTE-1:0] result
);

   assign result = INV_SBOX[data];

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// InvSubBytes stage: substitutes one 32-bit word of the captured state per
// cycle through LANES inverse S-boxes, then presents the full 128-bit result.
module inv_sub_bytes_seq
   import inv_sub_bytes_seq_pkg::*;
#(
   parameter int LANES = DWORD / BYTE
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [LENGTH-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [LENGTH-1:0] out_data,
   output logic              busy
);

   state_t            state;
   logic [1:0]        cnt;
   logic [LENGTH-1:0] in_reg;
   logic [DWORD-1:0]  word_cur;
   logic [DWORD-1:0]  word_sub;

   // Word k of the captured state feeds the S-box lanes while cnt == k.
   assign word_cur = in_reg[cnt*DWORD +: DWORD];

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      inv_sbox u_sbox (
         .data   (word_cur[g*BYTE +: BYTE]),
         .result (word_sub[g*BYTE +: BYTE])
      );
   end

   // A new state is taken when idle, or when the finished result leaves on the same edge.
   assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
   assign busy     = (state == BUSY);

   // Control FSM plus result register; out_data only moves on BUSY edges or reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 2'd0;
         out_valid <= 1'b0;
         out_data  <= '0;
         in_reg    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  in_reg <= in_data;
                  cnt    <= 2'd0;
                  state  <= BUSY;
               end
            end
            BUSY: begin
               out_data[cnt*DWORD +: DWORD] <= word_sub;
               cnt <= cnt + 2'd1;
               if (cnt == 2'd3) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (in_valid) begin
                     in_reg <= in_data;
                     cnt    <= 2'd0;
                     state  <= BUSY;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Bench for inv_sub_bytes_seq: transaction-level model built from GF(2^8)
// arithmetic, per-cycle compare, directed literal vectors and a round-trip run.
module tb_inv_sub_bytes_seq;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic         busy;

   int errors = 0;
   int checks = 0;

   inv_sub_bytes_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // S-box tables derived from the field definition, not from the design's table.
   logic [7:0] fwd  [256];
   logic [7:0] invt [256];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] affine(input logic [7:0] b);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] inv_state(input logic [127:0] d);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[i*8 +: 8] = invt[d[i*8 +: 8]];
      return r;
   endfunction

   function automatic logic [127:0] fwd_state(input logic [127:0] d);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[i*8 +: 8] = fwd[d[i*8 +: 8]];
      return r;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Transaction model: an accepted state is due 4 edges later and held until taken.
   logic         m_on = 1'b0;
   int           m_cnt = 0;
   logic         m_have = 1'b0;
   logic [127:0] m_out = '0;
   logic [127:0] m_pend = '0;
   logic         m_rdy;
   logic [127:0] sb_exp;
   logic [127:0] sb [$];
   int           cyc = 0;
   int           last_pop = -1;

   always @(negedge clk) begin
      cyc++;
      if (m_on) begin
         m_rdy = (m_cnt == 0) && (!m_have || out_ready);
         chk("m_in_ready", {127'd0, in_ready}, {127'd0, m_rdy});
         chk("m_out_valid", {127'd0, out_valid}, {127'd0, m_have});
         chk("m_busy", {127'd0, busy}, {127'd0, m_cnt != 0});
         if (m_cnt == 0) chk("m_out_data", out_data, m_out);
      end
      if (rst) begin
         m_on   = 1'b1;
         m_cnt  = 0;
         m_have = 1'b0;
         m_out  = '0;
      end else if (m_on) begin
         m_rdy = (m_cnt == 0) && (!m_have || out_ready);
         if (m_have && out_ready) begin
            m_have = 1'b0;
            if (sb.size() > 0) begin
               sb_exp = sb.pop_front();
               chk("rt_data", out_data, sb_exp);
               if (last_pop >= 0) chk("rt_interval", 128'(cyc - last_pop), 128'd5);
               last_pop = cyc;
            end
         end
         if (in_valid && m_rdy) begin
            m_pend = inv_state(in_data);
            m_cnt  = 4;
         end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
               m_have = 1'b1;
               m_out  = m_pend;
            end
         end
      end
   end

   task automatic send(input logic [127:0] d);
      bit acc;
      int n;
      in_data  = d;
      in_valid = 1'b1;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: in_ready low for %0d cycles, required high", n);
      end
   endtask

   task automatic wait_valid(output int k);
      k = 0;
      do begin
         @(posedge clk);
         #1;
         k++;
      end while (!out_valid && k < 20);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      int k;
      logic [7:0] gi;
      logic seen;
      logic [127:0] s;

      rst = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      out_ready = 1'b0;

      for (int x = 0; x < 256; x++) begin
         gi = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) gi = 8'(y);
         fwd[x] = affine(gi);
      end
      for (int x = 0; x < 256; x++) invt[fwd[x]] = 8'(x);

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // reset state
      chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
      chk("rst_out_data", out_data, 128'd0);
      chk("rst_busy", {127'd0, busy}, 128'd0);
      chk("rst_in_ready", {127'd0, in_ready}, 128'd1);

      // inverse lookup and latency
      out_ready = 1'b1;
      send({16{8'h63}});
      wait_valid(k);
      chk("lat_63", 128'(k), 128'd4);
      chk("data_63", out_data, 128'h0);
      send(128'h0);
      wait_valid(k);
      chk("lat_00", 128'(k), 128'd4);
      chk("data_00", out_data, {16{8'h52}});
      repeat (2) @(posedge clk);
      #1;

      // byte ordering
      send({8'h16, {14{8'h63}}, 8'h7C});
      wait_valid(k);
      chk("order", out_data, {8'hFF, 112'h0, 8'h01});
      repeat (2) @(posedge clk);
      #1;

      // backpressure then handoff
      out_ready = 1'b0;
      send(128'h0);
      wait_valid(k);
      chk("bp_valid_first", {127'd0, out_valid}, 128'd1);
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
         @(negedge clk);
         chk("bp_in_ready", {127'd0, in_ready}, 128'd0);
         chk("bp_out_valid", {127'd0, out_valid}, 128'd1);
         chk("bp_out_data", out_data, {16{8'h52}});
         @(posedge clk);
         #1;
      end
      in_data = {16{8'hED}};
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("ho_busy", {127'd0, busy}, 128'd1);
      chk("ho_out_valid", {127'd0, out_valid}, 128'd0);
      wait_valid(k);
      chk("ho_lat", 128'(k), 128'd4);
      chk("ho_data", out_data, {16{8'h53}});
      repeat (2) @(posedge clk);
      #1;

      // reset at counter == 2
      send({$urandom(), $urandom(), $urandom(), $urandom()});
      @(posedge clk);
      #1;
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("mr_in_ready", {127'd0, in_ready}, 128'd1);
      chk("mr_out_valid", {127'd0, out_valid}, 128'd0);
      chk("mr_out_data", out_data, 128'h0);
      chk("mr_busy", {127'd0, busy}, 128'd0);
      seen = 1'b0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      chk("mr_no_stale", {127'd0, seen}, 128'd0);

      // round trip through forward SubBytes, back-to-back
      for (int i = 0; i < 1000; i++) begin
         s = {$urandom(), $urandom(), $urandom(), $urandom()};
         sb.push_back(s);
         send(fwd_state(s));
      end
      k = 0;
      while (sb.size() > 0 && k < 50) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("rt_drained", 128'(sb.size()), 128'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
